// File: rtl/palindrome_pkg.sv
// Shared defaults, FSM state encoding and index-width helper for the palindrome generator.
package palindrome_pkg;

  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 8;
  localparam int IDX_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_e;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/palindrome_if.sv
// Upstream byte stream, downstream palindrome stream and overflow flag of the generator.
interface palindrome_if
  import palindrome_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_odd;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;
  logic         ovf;

  modport master (
    output in_valid, in_data, in_last, in_odd, out_ready,
    input  in_ready, out_valid, out_data, out_last, ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, in_odd, out_ready,
    output in_ready, out_valid, out_data, out_last, ovf
  );

endinterface

// File: rtl/palindrome_buf.sv
// Half-sequence storage: DEPTH x W registers, one synchronous write port, one combinational read port.
module palindrome_buf
  import palindrome_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IW    = idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [IW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // Contents are only read after being written, so no reset is needed.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/palindrome_gen.sv
// Loads a half-sequence and replays it forward then mirrored to form a palindrome.
module palindrome_gen
  import palindrome_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic         clk,
  input logic         rst_n,
  palindrome_if.slave bus
);

  // state | meaning
  // LOAD  | accepting half-sequence bytes into the buffer
  // FWD   | emitting buf[0..len-1]
  // REV   | emitting the mirrored tail; idx==0 closes the palindrome
  localparam int IW = idx_w(DEPTH);

  localparam logic [1:0]    S_LOAD  = 2'(LOAD);
  localparam logic [1:0]    S_FWD   = 2'(FWD);
  localparam logic [1:0]    S_REV   = 2'(REV);
  localparam logic [IW-1:0] CNT_MAX = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [IW:0]   LEN_ONE = 1;

  logic [1:0]    state;
  logic [IW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW:0]   len;
  logic          odd;

  logic          in_hs;
  logic          out_hs;
  logic          at_cap;
  logic          load_end;
  logic          idx_at_end;
  logic          single_odd;
  logic [IW:0]   len_m1;

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.out_valid = (state == S_FWD) || (state == S_REV);

  assign in_hs      = bus.in_valid && bus.in_ready;
  assign out_hs     = bus.out_valid && bus.out_ready;
  assign at_cap     = (cnt == CNT_MAX);
  assign load_end   = in_hs && (bus.in_last || at_cap);
  assign len_m1     = len - LEN_ONE;
  assign idx_at_end = ({1'b0, idx} == len_m1);
  assign single_odd = odd && (len == LEN_ONE);

  // Truncation pulse coincides with the accept of the byte that fills the buffer.
  assign bus.ovf = in_hs && at_cap && !bus.in_last;

  assign bus.out_last = ((state == S_FWD) && single_odd) ||
                        ((state == S_REV) && (idx == '0));

  palindrome_buf #(
    .W     (W),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_buf (
    .clk   (clk),
    .we    (in_hs),
    .waddr (cnt),
    .wdata (bus.in_data),
    .raddr (idx),
    .rdata (bus.out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_LOAD;
      cnt   <= '0;
      idx   <= '0;
      len   <= '0;
      odd   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_end) begin
            len   <= {1'b0, cnt} + LEN_ONE;
            odd   <= bus.in_last && bus.in_odd;
            idx   <= '0;
            cnt   <= '0;
            state <= S_FWD;
          end else if (in_hs) begin
            cnt <= cnt + IDX_ONE;
          end
        end
        S_FWD: begin
          if (out_hs) begin
            if (!idx_at_end) begin
              idx <= idx + IDX_ONE;
            end else if (single_odd) begin
              state <= S_LOAD;
            end else begin
              // Odd length skips the centre byte on the way back.
              state <= S_REV;
              if (odd) begin
                idx <= idx - IDX_ONE;
              end
            end
          end
        end
        S_REV: begin
          if (out_hs) begin
            if (idx != '0) begin
              idx <= idx - IDX_ONE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
